// File: rtl/midi_pkg.sv
// Shared constants and state encoding for the MIDI voice allocator.
package midi_pkg;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam int AGE_W = 8;
   localparam logic [AGE_W-1:0] AGE_MAX = 8'd255;
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2} alloc_state_e;
endpackage

// File: rtl/midi_voice_allocator_if.sv
// Message handshake between the MIDI parser (master) and the voice allocator (slave).
interface midi_voice_allocator_if;
   logic        msg_valid;
   logic [23:0] msg_bytes;
   logic        msg_ready;
   modport master (output msg_valid, output msg_bytes, input msg_ready);
   modport slave  (input msg_valid, input msg_bytes, output msg_ready);
endinterface

// File: rtl/midi_voice_slot.sv
// One voice slot: gate, note, velocity and age registers with load/release/age strobes.
module midi_voice_slot
   import midi_pkg::*;
(
   input  logic             clock,
   input  logic             clr,
   input  logic             load,
   input  logic             rel,
   input  logic             age_inc,
   input  logic [6:0]       note_in,
   input  logic [6:0]       vel_in,
   output logic             gate,
   output logic [6:0]       note,
   output logic [6:0]       vel,
   output logic [AGE_W-1:0] age
);
   logic             gate_q, gate_d;
   logic [6:0]       note_q, note_d;
   logic [6:0]       vel_q, vel_d;
   logic [AGE_W-1:0] age_q, age_d;

   always_comb begin
      gate_d = gate_q;
      note_d = note_q;
      vel_d  = vel_q;
      age_d  = age_q;
      if (load) begin
         gate_d = 1'b1;
         note_d = note_in;
         vel_d  = vel_in;
         age_d  = '0;
      end else begin
         if (rel) gate_d = 1'b0;
         // Only sounding voices grow older; the count saturates.
         if (age_inc && gate_q && (age_q != AGE_MAX)) age_d = age_q + AGE_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (clr) begin
         gate_q <= 1'b0;
         note_q <= '0;
         vel_q  <= '0;
         age_q  <= '0;
      end else begin
         gate_q <= gate_d;
         note_q <= note_d;
         vel_q  <= vel_d;
         age_q  <= age_d;
      end
   end

   assign gate = gate_q;
   assign note = note_q;
   assign vel  = vel_q;
   assign age  = age_q;
endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: one-voice-per-cycle scan, then a single commit cycle
// that reuses a matching voice, else a free one, else steals the oldest.
module midi_voice_allocator
   import midi_pkg::*;
#(
   parameter int VOICES  = 4,
   parameter int CHANNEL = 0
) (
   input  logic                  clock,
   input  logic                  clr,
   midi_voice_allocator_if.slave msg_if,
   output logic [VOICES-1:0]     voice_gate,
   output logic [7*VOICES-1:0]   voice_note,
   output logic [7*VOICES-1:0]   voice_vel,
   output logic                  steal_pulse
);
   localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam logic [3:0] CH = 4'(CHANNEL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

   alloc_state_e     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             on_q, on_d;
   logic [6:0]       note_q, note_d, vel_q, vel_d;
   logic             match_found_q, match_found_d, free_found_q, free_found_d;
   logic [IDX_W-1:0] match_idx_q, match_idx_d, free_idx_q, free_idx_d, oldest_idx_q, oldest_idx_d;
   logic [AGE_W-1:0] oldest_age_q, oldest_age_d;
   logic             steal_q, steal_d;

   logic             gate_w [VOICES];
   logic [6:0]       note_w [VOICES];
   logic [6:0]       vel_w  [VOICES];
   logic [AGE_W-1:0] age_w  [VOICES];
   logic [VOICES-1:0] load_s, rel_s, inc_s;

   logic [3:0] in_status, in_chan;
   logic [6:0] in_note, in_vel;
   logic       is_on, is_off, msg_ready, commit_en, unused_bits;
   logic [IDX_W-1:0] tgt_idx;

   assign in_status   = msg_if.msg_bytes[23:20];
   assign in_chan     = msg_if.msg_bytes[19:16];
   assign in_note     = msg_if.msg_bytes[14:8];
   assign in_vel      = msg_if.msg_bytes[6:0];
   assign unused_bits = ^{msg_if.msg_bytes[15], msg_if.msg_bytes[7]};
   assign is_on  = (in_status == NOTE_ON) && (in_chan == CH) && (in_vel != 7'd0);
   assign is_off = (in_chan == CH) &&
                   ((in_status == NOTE_OFF) || ((in_status == NOTE_ON) && (in_vel == 7'd0)));

   assign msg_ready        = (state_q == IDLE) && !clr;
   assign msg_if.msg_ready = msg_ready;
   assign commit_en        = (state_q == COMMIT);
   assign tgt_idx = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : oldest_idx_q);

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      on_d          = on_q;
      note_d        = note_q;
      vel_d         = vel_q;
      match_found_d = match_found_q;
      match_idx_d   = match_idx_q;
      free_found_d  = free_found_q;
      free_idx_d    = free_idx_q;
      oldest_idx_d  = oldest_idx_q;
      oldest_age_d  = oldest_age_q;
      steal_d       = 1'b0;
      case (state_q)
         IDLE: begin
            // Anything that is neither Note On nor Note Off is consumed here.
            if (msg_if.msg_valid && msg_ready && (is_on || is_off)) begin
               state_d       = SCAN;
               idx_d         = '0;
               on_d          = is_on;
               note_d        = in_note;
               vel_d         = in_vel;
               match_found_d = 1'b0;
               match_idx_d   = '0;
               free_found_d  = 1'b0;
               free_idx_d    = '0;
               oldest_idx_d  = '0;
               oldest_age_d  = '0;
            end
         end
         SCAN: begin
            if (gate_w[idx_q] && (note_w[idx_q] == note_q) && !match_found_q) begin
               match_found_d = 1'b1;
               match_idx_d   = idx_q;
            end
            if (!gate_w[idx_q] && !free_found_q) begin
               free_found_d = 1'b1;
               free_idx_d   = idx_q;
            end
            // Strict compare keeps the lowest index on equal ages.
            if (age_w[idx_q] > oldest_age_q) begin
               oldest_age_d = age_w[idx_q];
               oldest_idx_d = idx_q;
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state_d = COMMIT;
         end
         COMMIT: begin
            state_d = IDLE;
            steal_d = on_q && !match_found_q && !free_found_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clr) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         on_q          <= 1'b0;
         note_q        <= '0;
         vel_q         <= '0;
         match_found_q <= 1'b0;
         match_idx_q   <= '0;
         free_found_q  <= 1'b0;
         free_idx_q    <= '0;
         oldest_idx_q  <= '0;
         oldest_age_q  <= '0;
         steal_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         on_q          <= on_d;
         note_q        <= note_d;
         vel_q         <= vel_d;
         match_found_q <= match_found_d;
         match_idx_q   <= match_idx_d;
         free_found_q  <= free_found_d;
         free_idx_q    <= free_idx_d;
         oldest_idx_q  <= oldest_idx_d;
         oldest_age_q  <= oldest_age_d;
         steal_q       <= steal_d;
      end
   end

   for (genvar i = 0; i < VOICES; i++) begin : g_voice
      assign load_s[i] = commit_en && on_q && (tgt_idx == IDX_W'(i));
      assign rel_s[i]  = commit_en && !on_q && match_found_q && (match_idx_q == IDX_W'(i));
      assign inc_s[i]  = commit_en && on_q && (tgt_idx != IDX_W'(i));

      midi_voice_slot u_slot (
         .clock   (clock),
         .clr     (clr),
         .load    (load_s[i]),
         .rel     (rel_s[i]),
         .age_inc (inc_s[i]),
         .note_in (note_q),
         .vel_in  (vel_q),
         .gate    (gate_w[i]),
         .note    (note_w[i]),
         .vel     (vel_w[i]),
         .age     (age_w[i])
      );

      assign voice_gate[i]       = gate_w[i];
      assign voice_note[7*i +: 7] = note_w[i];
      assign voice_vel[7*i +: 7]  = vel_w[i];
   end

   assign steal_pulse = steal_q;
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: directed vector table, clr-abort sequence, random vs reference model.
module tb_midi_voice_allocator;
   localparam int V = 4;

   logic clock = 1'b0;
   logic clr;
   always #5 clock = ~clock;

   midi_voice_allocator_if bus ();
   logic [V-1:0]   voice_gate;
   logic [7*V-1:0] voice_note, voice_vel;
   logic           steal_pulse;

   midi_voice_allocator #(.VOICES(V), .CHANNEL(0)) dut (
      .clock       (clock),
      .clr         (clr),
      .msg_if      (bus),
      .voice_gate  (voice_gate),
      .voice_note  (voice_note),
      .voice_vel   (voice_vel),
      .steal_pulse (steal_pulse)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: voice table updated straight from the allocation rules.
   bit m_gate [V];
   int m_note [V];
   int m_vel  [V];
   int m_age  [V];

   task automatic model_reset();
      for (int i = 0; i < V; i++) begin
         m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
      end
   endtask

   task automatic model_apply(input logic [23:0] m, output bit evt, output bit steal);
      logic [23:0] mm;
      int st, ch, n, vl, tgt;
      bit on, off;
      mm = m;
      st = int'(mm[23:20]); ch = int'(mm[19:16]); n = int'(mm[14:8]); vl = int'(mm[6:0]);
      on  = (st == 9) && (ch == 0) && (vl != 0);
      off = (ch == 0) && ((st == 8) || ((st == 9) && (vl == 0)));
      evt = on || off;
      steal = 0;
      tgt = -1;
      for (int i = 0; i < V; i++)
         if (tgt < 0 && m_gate[i] && m_note[i] == n) tgt = i;
      if (off) begin
         if (tgt >= 0) m_gate[tgt] = 0;
      end else if (on) begin
         if (tgt < 0)
            for (int i = 0; i < V; i++)
               if (tgt < 0 && !m_gate[i]) tgt = i;
         if (tgt < 0) begin
            tgt = 0;
            for (int i = 1; i < V; i++)
               if (m_age[i] > m_age[tgt]) tgt = i;
            steal = 1;
         end
         for (int i = 0; i < V; i++)
            if (i != tgt && m_gate[i] && m_age[i] < 255) m_age[i]++;
         m_gate[tgt] = 1; m_note[tgt] = n; m_vel[tgt] = vl; m_age[tgt] = 0;
      end
   endtask

   task automatic model_vectors(output logic [V-1:0] g, output logic [7*V-1:0] n,
                                output logic [7*V-1:0] vv);
      for (int i = 0; i < V; i++) begin
         g[i] = m_gate[i];
         n[7*i +: 7]  = 7'(m_note[i]);
         vv[7*i +: 7] = 7'(m_vel[i]);
      end
   endtask

   task automatic check_voices(input string tag, input logic [V-1:0] g,
                               input logic [7*V-1:0] n, input logic [7*V-1:0] vv);
      chk({tag, " gate"}, 64'(voice_gate), 64'(g));
      chk({tag, " note"}, 64'(voice_note), 64'(n));
      chk({tag, " vel"},  64'(voice_vel),  64'(vv));
   endtask

   // Handshake one message and check the busy window; returns steal_pulse after
   // the commit edge and one cycle later.
   task automatic send(input logic [23:0] m, input bit evt,
                       output logic steal_seen, output logic steal_after);
      int  waits;
      bit  busy_ok;
      waits = 0;
      @(negedge clock);
      while (bus.msg_ready !== 1'b1 && waits < 20) begin
         @(negedge clock);
         waits++;
      end
      chk("ready_before_send", 64'(bus.msg_ready), 64'(1));
      bus.msg_valid = 1'b1;
      bus.msg_bytes = m;
      @(posedge clock);
      #1;
      bus.msg_valid = 1'b0;
      bus.msg_bytes = 24'h0;
      if (!evt) begin
         chk("drop_ready", 64'(bus.msg_ready), 64'(1));
         steal_seen  = steal_pulse;
         steal_after = steal_pulse;
      end else begin
         busy_ok = (bus.msg_ready === 1'b0);
         for (int k = 1; k <= V; k++) begin
            @(posedge clock);
            #1;
            if (bus.msg_ready !== 1'b0) busy_ok = 0;
         end
         chk("busy_window", 64'(busy_ok), 64'(1));
         @(posedge clock);
         #1;
         chk("ready_after_commit", 64'(bus.msg_ready), 64'(1));
         steal_seen = steal_pulse;
         @(posedge clock);
         #1;
         steal_after = steal_pulse;
      end
   endtask

   typedef struct {
      logic [23:0]    msg;
      bit             evt;
      bit             steal;
      logic [V-1:0]   gate;
      logic [7*V-1:0] note;
      logic [7*V-1:0] vel;
   } vec_t;

   vec_t tbl [15];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic ss, sa;
      bit   evt, es;
      logic [V-1:0]   eg;
      logic [7*V-1:0] en, ev;
      logic [23:0]    m;
      int   r;

      tbl[0]  = '{24'h903C64, 1, 0, 4'b0001, {7'h00,7'h00,7'h00,7'h3C}, {7'h00,7'h00,7'h00,7'h64}};
      tbl[1]  = '{24'h903E51, 1, 0, 4'b0011, {7'h00,7'h00,7'h3E,7'h3C}, {7'h00,7'h00,7'h51,7'h64}};
      tbl[2]  = '{24'h904052, 1, 0, 4'b0111, {7'h00,7'h40,7'h3E,7'h3C}, {7'h00,7'h52,7'h51,7'h64}};
      tbl[3]  = '{24'h904353, 1, 0, 4'b1111, {7'h43,7'h40,7'h3E,7'h3C}, {7'h53,7'h52,7'h51,7'h64}};
      tbl[4]  = '{24'h904550, 1, 1, 4'b1111, {7'h43,7'h40,7'h3E,7'h45}, {7'h53,7'h52,7'h51,7'h50}};
      tbl[5]  = '{24'h803E00, 1, 0, 4'b1101, {7'h43,7'h40,7'h3E,7'h45}, {7'h53,7'h52,7'h51,7'h50}};
      tbl[6]  = '{24'h904000, 1, 0, 4'b1001, {7'h43,7'h40,7'h3E,7'h45}, {7'h53,7'h52,7'h51,7'h50}};
      tbl[7]  = '{24'h904830, 1, 0, 4'b1011, {7'h43,7'h40,7'h48,7'h45}, {7'h53,7'h52,7'h30,7'h50}};
      tbl[8]  = '{24'h904530, 1, 0, 4'b1011, {7'h43,7'h40,7'h48,7'h45}, {7'h53,7'h52,7'h30,7'h30}};
      tbl[9]  = '{24'h913C64, 0, 0, 4'b1011, {7'h43,7'h40,7'h48,7'h45}, {7'h53,7'h52,7'h30,7'h30}};
      tbl[10] = '{24'hB00740, 0, 0, 4'b1011, {7'h43,7'h40,7'h48,7'h45}, {7'h53,7'h52,7'h30,7'h30}};
      tbl[11] = '{24'h803E7F, 1, 0, 4'b1011, {7'h43,7'h40,7'h48,7'h45}, {7'h53,7'h52,7'h30,7'h30}};
      tbl[12] = '{24'h90C8B1, 1, 0, 4'b1011, {7'h43,7'h40,7'h48,7'h45}, {7'h53,7'h52,7'h31,7'h30}};
      tbl[13] = '{24'h905010, 1, 0, 4'b1111, {7'h43,7'h50,7'h48,7'h45}, {7'h53,7'h10,7'h31,7'h30}};
      tbl[14] = '{24'h905511, 1, 1, 4'b1111, {7'h55,7'h50,7'h48,7'h45}, {7'h11,7'h10,7'h31,7'h30}};

      bus.msg_valid = 1'b0;
      bus.msg_bytes = 24'h0;
      clr = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_ready", 64'(bus.msg_ready), 64'(0));
      chk("reset_steal", 64'(steal_pulse), 64'(0));
      check_voices("reset", '0, '0, '0);
      @(negedge clock);
      clr = 1'b0;

      for (int i = 0; i < 15; i++) begin
         send(tbl[i].msg, tbl[i].evt, ss, sa);
         check_voices($sformatf("vec%0d", i), tbl[i].gate, tbl[i].note, tbl[i].vel);
         chk($sformatf("vec%0d steal", i), 64'(ss), 64'(tbl[i].steal));
         chk($sformatf("vec%0d steal_next", i), 64'(sa), 64'(0));
      end

      // clr one cycle after an accept aborts the operation.
      @(negedge clock);
      bus.msg_valid = 1'b1;
      bus.msg_bytes = 24'h903C64;
      @(posedge clock);
      #1;
      bus.msg_valid = 1'b0;
      @(negedge clock);
      clr = 1'b1;
      @(posedge clock);
      #1;
      check_voices("abort", '0, '0, '0);
      chk("abort_steal", 64'(steal_pulse), 64'(0));
      chk("abort_ready_in_clr", 64'(bus.msg_ready), 64'(0));
      @(negedge clock);
      clr = 1'b0;
      #1;
      chk("abort_ready_after", 64'(bus.msg_ready), 64'(1));
      repeat (V + 3) @(posedge clock);
      #1;
      check_voices("abort_no_commit", '0, '0, '0);
      model_reset();

      for (int t = 0; t < 60; t++) begin
         r = $urandom_range(0, 9);
         m = {8'h90, 1'($urandom), 7'(7'h3C + $urandom_range(0, 5)),
              1'($urandom), 7'($urandom_range(1, 127))};
         if (r >= 5 && r <= 6) m[23:20] = 4'h8;
         else if (r == 7) m[6:0] = 7'h00;
         else if (r == 8) m[19:16] = 4'($urandom_range(1, 15));
         else if (r == 9) m[23:16] = 8'hB0;
         model_apply(m, evt, es);
         send(m, evt, ss, sa);
         model_vectors(eg, en, ev);
         check_voices($sformatf("rnd%0d msg=%06h", t, m), eg, en, ev);
         chk($sformatf("rnd%0d steal", t), 64'(ss), 64'(es));
         chk($sformatf("rnd%0d steal_next", t), 64'(sa), 64'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

Polyphonic voice scheduler between the MIDI receiver and the synth voice bank. Takes parsed 3-byte MIDI messages (status, data1, data2), filters on one channel, and assigns Note On events to a fixed pool of voices. When a matching note is already sounding, it reuses that voice; otherwise it uses a free voice, and when none is free it steals the oldest. Note Off events release the matching voice.

## Interface
- VOICES, 4: number of voice slots, 2..16.
- CHANNEL, 0: MIDI channel accepted, 0..15.
- clock  in  1  system clock; all logic on posedge.
- clr  in  1  synchronous active-high reset.
- msg_valid  in  1  a message is present on msg_bytes.
- msg_bytes  in  24  {status, data1, data2}; status in [23:16].
- msg_ready  out  1  block can accept a message.
- voice_gate  out  VOICES  per-voice gate; 1 = sounding.
- voice_note  out  7*VOICES  note number; voice i in [7i+6:7i].
- voice_vel  out  7*VOICES  velocity; same packing.
- steal_pulse  out  1  one-cycle pulse on a commit that stole an active voice.

## Operation
- Reset values: all gates 0, notes 0, velocities 0, ages 0, steal_pulse 0, and state IDLE. While clr is high, msg_ready is 0.
- Accept: msg_valid && msg_ready at a posedge. Only IDLE holds msg_ready=1.
- Decode:
  - Status [23:20]=9 with [19:16]=CHANNEL and data2[6:0]≠0 is a Note On.
  - 9 with velocity 0, or 8 with matching channel, is a Note Off.
  - Note = [14:8]; velocity = [6:0]. Bit 7 of each data byte is ignored.
- Drops: any other message, or a channel mismatch, is accepted and dropped. The state stays IDLE and msg_ready stays 1.
- States:
  - IDLE to SCAN on accepting a Note On or Note Off. The decoded message is latched, idx=0, and scan flags are cleared.
  - SCAN: one voice per cycle, idx 0..VOICES-1. Records the lowest-index voice that is gated with the same note (match), the lowest-index voice with gate 0 (free), and the voice with the largest age, ties going to the lowest index (oldest). After idx=VOICES-1, go to COMMIT.
  - COMMIT: a single cycle that writes the voice registers, then returns to IDLE.
- Note On target, in priority order: match, then free, then oldest.
  - Target gets gate=1, note and velocity loaded, age=0.
  - Every other gated voice gets age+1, saturating at 255.
  - steal_pulse=1 only when the target is the oldest voice and that voice was gated.
- Note Off: on a match, clear that voice's gate. Note, velocity and age are kept. No match means no change. Ages are unchanged.
- Age is 8 bits per voice. Ungated voices keep their age, but the free rule wins over age for them.
- clr during SCAN or COMMIT aborts the operation. The message is lost, with no partial commit.

## Timing
- Accept at edge 0. SCAN occupies edges 1..VOICES. COMMIT happens at edge VOICES+1.
- voice_* outputs and steal_pulse are registered. They change at edge VOICES+1. steal_pulse is high for exactly the following cycle.
- msg_ready is low from just after edge 0 until edge VOICES+1. The next accept is possible at edge VOICES+2. Throughput is one note event per VOICES+2 cycles.
- A dropped message costs 0 busy cycles.
- The first accept is possible at the first posedge after clr deasserts.
- msg_valid while msg_ready=0 is ignored. The producer must hold the message until the handshake completes.

## Structure
- Shared package midi_pkg holds:
  - status-nibble constants NOTE_ON=4'h9 and NOTE_OFF=4'h8;
  - the allocator state encoding IDLE/SCAN/COMMIT;
  - AGE_W=8 and AGE_MAX=255.
- Sub-module midi_voice_slot: one per voice, generated VOICES times. It holds gate, note, velocity and age. It takes load, release and age_inc strobes plus note/velocity inputs, and exposes its registers to the scan mux.
- The top level holds the FSM, message latch, scan index and comparators, and target select.

## Test plan
All scenarios use VOICES=4, CHANNEL=0.
- Reset, then msg 0x903C64 → at edge 5 voice0 has gate=1, note=0x3C, vel=0x64. msg_ready is low for 5 cycles. steal_pulse stays 0.
- Note Ons 0x3C, 0x3E, 0x40, 0x43, then 0x904550 → voices 0..3 filled. The fifth message steals voice0 (age 3): note=0x45, vel=0x50, steal_pulse high for 1 cycle.
- With voices full, send 0x803E00 then 0x904000 → voices 1 and 2 have gate=0 with notes 0x3E and 0x40 retained. A following Note On 0x904830 lands in voice1.
- With 0x3C sounding, send 0x903C20 → the same voice is retriggered with vel=0x20 and age=0. No second voice is gated and there is no steal.
- Send 0x913C64 and 0xB00740 → both are dropped. msg_ready stays 1 and no voice_* change occurs.
- Assert clr one cycle after accepting 0x903C64 → all outputs are 0 the next cycle. The message is lost. msg_ready is 1 after clr falls.
